// File: rtl/video_pattern_if.sv
// video_pattern_if: pattern-select input and registered pixel/sync/status outputs of one display pipe.
interface video_pattern_if #(parameter int CW = 8);
  logic [1:0] mode;
  logic [CW-1:0] r, g, b;
  logic de, hsync, vsync;
  logic [7:0] frame;
  modport master(input mode, output r, g, b, de, hsync, vsync, frame);
  modport slave(output mode, input r, g, b, de, hsync, vsync, frame);
endinterface

// File: rtl/video_pattern.sv
// video_pattern: four-mode test-pattern generator on a video_control raster; VIDEO_PATTERN_ANIM_EN enables the frame counter.
module video_control #(
  parameter int HDE = 639, HSS = 687, HSE = 719, HE = 799,
  parameter int VDE = 479, VSS = 482, VSE = 486, VE = 493,
  parameter int HW = $clog2(HE), VW = $clog2(VE)
) (
  input  logic clock,
  input  logic reset,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic hde, vde, hsync, vsync
);
  localparam logic [HW-1:0] XDE = HW'(HDE), XSS = HW'(HSS), XSE = HW'(HSE), XE = HW'(HE);
  localparam logic [VW-1:0] YDE = VW'(VDE), YSS = VW'(VSS), YSE = VW'(VSE), YE = VW'(VE);
  always_ff @(posedge clock)
    if (reset) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= (x == XE) ? '0 : x + 1'b1;
      if (x == XE) y <= (y == YE) ? '0 : y + 1'b1;
    end
  assign hde = x <= XDE;
  assign vde = y <= YDE;
  assign hsync = x >= XSS && x <= XSE;
  assign vsync = y >= YSS && y <= YSE;
endmodule

module video_pattern #(
  parameter int HDE = 639, HSS = 687, HSE = 719, HE = 799,
  parameter int VDE = 479, VSS = 482, VSE = 486, VE = 493,
  parameter int CW = 8, SQ = 5
) (
  input logic clock,
  input logic reset,
  video_pattern_if.master vp
);
  localparam int HW = $clog2(HE), VW = $clog2(VE), BW = (HDE + 1) / 8;
  localparam logic [HW-1:0] XE = HW'(HE), BL = HW'(BW - 1);
  localparam logic [VW-1:0] YE = VW'(VE);
  logic [HW-1:0] x, cnt_q, cnt;
  logic [VW-1:0] y;
  logic hde, vde, hs, vs, vis, eof, chk;
  logic [1:0] mode_q;
  logic [2:0] idx_q, idx;
  logic [7:0] frame_q;
  logic [23:0] gc;
  logic [CW-1:0] cr, cg, cb;
  function automatic logic [23:0] grid(input logic [4:0] c);
    return c < 5'd21 ? 24'h105003 : (c == 5'd21 || c == 5'd31) ? 24'hE03010 : 24'h703005;
  endfunction
  // Left-align the byte and refill the low bits from its MSBs, so 00/FF stay black/white.
  function automatic logic [CW-1:0] expand(input logic [7:0] v);
    return CW'({v, v} >> (16 - CW));
  endfunction
  video_control #(.HDE(HDE), .HSS(HSS), .HSE(HSE), .HE(HE), .VDE(VDE), .VSS(VSS), .VSE(VSE), .VE(VE))
    u_ctl (.clock(clock), .reset(reset), .x(x), .y(y), .hde(hde), .vde(vde), .hsync(hs), .vsync(vs));
  always_comb begin
    vis = hde & vde;
    eof = x == XE && y == YE;
    cnt = (x == '0) ? '0 : cnt_q;
    idx = (x == '0) ? '0 : idx_q;
    gc = grid(x[4:0]) | grid(y[4:0]);
    chk = x[SQ] ^ y[SQ] ^ frame_q[5];
    cr = mode_q == 2'd0 ? expand(gc[23:16]) : mode_q == 2'd1 ? {CW{~idx[1]}} :
         mode_q == 2'd2 ? CW'(x) + CW'(frame_q) : {CW{chk}};
    cg = mode_q == 2'd0 ? expand(gc[15:8]) : mode_q == 2'd1 ? {CW{~idx[2]}} :
         mode_q == 2'd2 ? CW'(y) : {CW{chk}};
    cb = mode_q == 2'd0 ? expand(gc[7:0]) : mode_q == 2'd1 ? {CW{~idx[0]}} :
         mode_q == 2'd2 ? CW'({frame_q, 8'h00} >> (16 - CW)) : {CW{chk}};
  end
  always_ff @(posedge clock)
    if (reset) begin
      vp.r <= '0;
      vp.g <= '0;
      vp.b <= '0;
      vp.de <= 1'b0;
      vp.hsync <= 1'b0;
      vp.vsync <= 1'b0;
      mode_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      vp.r <= vis ? cr : '0;
      vp.g <= vis ? cg : '0;
      vp.b <= vis ? cb : '0;
      vp.de <= vis;
      vp.hsync <= hs;
      vp.vsync <= vs;
      cnt_q <= (cnt == BL) ? '0 : cnt + 1'b1;
      idx_q <= (cnt == BL && idx != 3'd7) ? idx + 1'b1 : idx;
      if (eof) mode_q <= vp.mode;
    end
`ifdef VIDEO_PATTERN_ANIM_EN
  always_ff @(posedge clock)
    if (reset) frame_q <= '0;
    else if (eof) frame_q <= frame_q + 1'b1;
`else
  assign frame_q = 8'd0;
`endif
  assign vp.frame = frame_q;
endmodule

// File: tb/tb_video_pattern.sv
// tb_video_pattern: raster-position scoreboard over a reduced timing so many frames fit in a short run.
module tb_video_pattern;
  localparam int HDE = 33, HSS = 35, HSE = 37, HE = 41;
  localparam int VDE = 15, VSS = 17, VSE = 19, VE = 23;
  localparam int CW = 10, SQ = 3, W = HE + 1, N = W * (VE + 1), BW = (HDE + 1) / 8;
`ifdef VIDEO_PATTERN_ANIM_EN
  localparam int ANIM = 1;
`else
  localparam int ANIM = 0;
`endif
  logic clk = 0, rst = 1;
  int tests = 0, fails = 0;
  int pos = 0, mf = 0, mm = 0;
  logic [CW-1:0] er = '0, eg = '0, eb = '0;
  logic ede = 0, ehs = 0, evs = 0;
  logic [3*CW+10:0] obs, expv;
  video_pattern_if #(.CW(CW)) vp();
  video_pattern #(.HDE(HDE), .HSS(HSS), .HSE(HSE), .HE(HE), .VDE(VDE), .VSS(VSS), .VSE(VSE), .VE(VE),
    .CW(CW), .SQ(SQ)) dut (.clock(clk), .reset(rst), .vp(vp));
  always #5 clk = ~clk;
  assign obs = {vp.r, vp.g, vp.b, vp.de, vp.hsync, vp.vsync, vp.frame};
  assign expv = {er, eg, eb, ede, ehs, evs, 8'(mf)};

  function automatic logic [23:0] gridc(int c);
    if (c < 21) return 24'h105003;
    if (c == 21 || c == 31) return 24'hE03010;
    return 24'h703005;
  endfunction
  function automatic logic [23:0] bar(int k);
    case (k)
      0: return 24'hFFFFFF; 1: return 24'hFFFF00; 2: return 24'h00FFFF; 3: return 24'h00FF00;
      4: return 24'hFF00FF; 5: return 24'hFF0000; 6: return 24'h0000FF; default: return 24'h000000;
    endcase
  endfunction
  function automatic logic [CW-1:0] ex(logic [7:0] v);
    int t = v;
    return CW'((t << (CW - 8)) | (t >> (16 - CW)));
  endfunction
  function automatic logic [3*CW-1:0] pix(int px, int py, int f, int m);
    logic [23:0] c;
    logic [CW-1:0] w;
    if (m == 2) return {CW'((px + f) % (1 << CW)), CW'(py % (1 << CW)), CW'(f << (CW - 8))};
    if (m == 3) begin
      w = (((px >> SQ) ^ (py >> SQ) ^ (f >> 5)) & 1) != 0 ? '1 : '0;
      return {w, w, w};
    end
    c = (m == 0) ? (gridc(px % 32) | gridc(py % 32)) : bar((px / BW > 7) ? 7 : px / BW);
    return {ex(c[23:16]), ex(c[15:8]), ex(c[7:0])};
  endfunction

  // Expected outputs after each edge, derived from the raster position at that edge.
  always @(posedge clk)
    if (rst) begin
      pos <= 0; mf <= 0; mm <= 0;
      {er, eg, eb} <= '0; ede <= 0; ehs <= 0; evs <= 0;
    end else begin
      {er, eg, eb} <= (pos % W <= HDE && pos / W <= VDE) ? pix(pos % W, pos / W, mf, mm) : '0;
      ede <= pos % W <= HDE && pos / W <= VDE;
      ehs <= pos % W >= HSS && pos % W <= HSE;
      evs <= pos / W >= VSS && pos / W <= VSE;
      pos <= (pos == N - 1) ? 0 : pos + 1;
      if (pos == N - 1) begin
        mm <= int'(vp.mode);
        mf <= (mf + ANIM) % 256;
      end
    end

  task automatic test_reset;
    rst = 1;
    vp.mode = 2'd0;
    repeat (3) begin
      @(negedge clk); tests++;
      if (obs !== '0) begin fails++; $display("FAIL reset: got %h required 0", obs); end
    end
    rst = 0;
  endtask

  task automatic test_grid;
    @(negedge clk); tests++;
    if ({vp.r, vp.g, vp.b, vp.de} !== {10'h040, 10'h141, 10'h00C, 1'b1}) begin
      fails++; $display("FAIL grid_first: got %h %h %h de=%b", vp.r, vp.g, vp.b, vp.de);
    end
    repeat (21) begin
      @(negedge clk); tests++;
      if (obs !== expv) begin fails++; $display("FAIL grid: got %h expected %h", obs, expv); end
    end
    tests++;
    if ({vp.r, vp.g, vp.b} !== {10'h3C3, 10'h1C1, 10'h04C}) begin
      fails++; $display("FAIL grid_x21: got %h %h %h", vp.r, vp.g, vp.b);
    end
    repeat (N + 50) begin
      @(negedge clk); tests++;
      if (obs !== expv) begin fails++; $display("FAIL grid: got %h expected %h", obs, expv); end
    end
  endtask

  task automatic test_mode_change(input logic [1:0] m, input int frames, input string name);
    repeat ($urandom_range(N - 100, 10)) begin
      @(negedge clk); tests++;
      if (obs !== expv) begin fails++; $display("FAIL %s pre: got %h expected %h", name, obs, expv); end
    end
    vp.mode = m;
    repeat (frames * N) begin
      @(negedge clk); tests++;
      if (obs !== expv) begin fails++; $display("FAIL %s: got %h expected %h", name, obs, expv); end
    end
  endtask

  task automatic test_random_modes;
    repeat (8) begin
      vp.mode = 2'($urandom_range(3, 0));
      repeat ($urandom_range(2 * N, 50)) begin
        @(negedge clk); tests++;
        if (obs !== expv) begin fails++; $display("FAIL random: got %h expected %h", obs, expv); end
      end
    end
  endtask

  task automatic test_reset_mid;
    vp.mode = 2'd2;
    repeat (N + $urandom_range(N - 100, 100)) begin
      @(negedge clk); tests++;
      if (obs !== expv) begin fails++; $display("FAIL rstmid pre: got %h expected %h", obs, expv); end
    end
    rst = 1;
    @(negedge clk); tests++;
    if (obs !== '0) begin fails++; $display("FAIL rstmid: got %h required 0", obs); end
    rst = 0;
    repeat (2 * N) begin
      @(negedge clk); tests++;
      if (obs !== expv) begin fails++; $display("FAIL rstmid post: got %h expected %h", obs, expv); end
    end
  endtask

  initial begin
    test_reset;
    test_grid;
    test_mode_change(2'd1, 2, "bars");
    test_mode_change(2'd2, 2, "gradient");
    test_mode_change(2'd3, 28, "checker");
    test_random_modes;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/video_pattern.md
# video_pattern

Parametrised video test-pattern generator: next generation of the fixed grid generator. Drives a `video_control` timing core and produces registered RGB plus `de`/`hsync`/`vsync` for one display pipe. Supports four run-time selectable patterns, configurable channel width, and an optional per-frame animation counter. Mode changes take effect only on frame boundaries.

## Interface

- `HDE`, 639: last visible pixel column.
- `HSS`, 687: first hsync column.
- `HSE`, 719: last hsync column.
- `HE`, 799: last column of line.
- `VDE`, 479: last visible line.
- `VSS`, 482: first vsync line.
- `VSE`, 486: last vsync line.
- `VE`, 493: last line of frame.
- `CW`, 8: bits per colour channel; legal range 8..16.
- `SQ`, 5: checkerboard square size is 2^SQ pixels; SQ < min(HW, VW).

Ports:

- `clock`  in  1  pixel clock; single clock domain.
- `reset`  in  1  synchronous, active-high.
- `mode`  in  2  pattern select; sampled only at end of frame.
- `r`, `g`, `b`  out  CW each  colour channels, registered.
- `de`  out  1  data enable (`hde & vde`), registered.
- `hsync`, `vsync`  out  1  sync from `video_control`, registered, active-high.
- `frame`  out  8  current frame number (debug/status).

## Operation

- Instantiates `video_control` with the timing parameters. It supplies `x` (HW = $clog2(HE) bits), `y` (VW = $clog2(VE) bits), `hde`, `vde`, `hsync` and `vsync`. Counters are 0 in the first cycle after reset release.
- End-of-frame event EOF is asserted when `x == HE && y == VE`. On EOF:
  - `mode_q <= mode`.
  - `frame <= frame + 1` (mod 256).
- Both updates apply from pixel (0,0) of the next frame. A `mode` change mid-frame never tears the image.
- 8-bit colour constants are expanded to CW bits by left-aligning the value and filling the low CW-8 bits with repeated copies of its MSBs. Bit replication rule: 8'hFF maps to all-ones, 8'h00 maps to zero.
- Modes (`mode_q`):
  - **0, grid.** The channel colour for coordinate bits c[4:0] is:
    - c < 21 → 24'h105003
    - c == 21 → 24'hE03010
    - 22..30 → 24'h703005
    - 31 → 24'hE03010
    
    Compute one colour from `x[4:0]` and one from `y[4:0]`, then bitwise-OR them. Each byte is expanded to CW.
  - **1, colour bars.**
    - Bar width BW = (HDE+1)/8 (integer).
    - A bar-pixel counter and a 3-bit bar index both reset when `x == 0`. The index increments when the counter reaches BW-1, and saturates at 7 (remainder pixels stay black).
    - Per channel: `r = ~i[1]`, `g = ~i[2]`, `b = ~i[0]`. A 1 maps to all-ones and a 0 maps to zero.
    - Resulting order: white, yellow, cyan, green, magenta, red, blue, black.
  - **2, gradient.**
    - `r = (x + frame) mod 2^CW` (x zero-extended).
    - `g = y mod 2^CW`.
    - `b = {frame, CW-8 zeros}`.
  - **3, checkerboard.** White (all-ones) when `x[SQ] ^ y[SQ] ^ frame[5]` is 1, else zero.
- Blanking: when `hde & vde` is 0, r/g/b are registered as 0 regardless of mode.

## Timing

- One register stage. `r`/`g`/`b`/`de`/`hsync`/`vsync` at cycle n+1 reflect control state (x, y, hde, vde, sync) at cycle n. All six outputs are aligned with each other.
- Reset values, effective in the cycle after `reset` is high:
  - outputs: r = g = b = 0, de = 0, hsync = 0, vsync = 0, `frame` = 0.
  - internal: `mode_q` = 0, bar counter and bar index = 0.
- Reset mid-frame: all of the above, and `video_control` restarts at (0,0). The pending `mode` is not captured; `mode_q` returns to 0 until the next EOF.
- Reset and EOF in the same cycle: reset wins.
- `frame` wraps 255 → 0 without any other side effect.
- The bar index resets on `x == 0` even if the previous line ended mid-bar.

## Configuration

- `VIDEO_PATTERN_ANIM_EN` defined: `frame` counter is implemented as above.
- Undefined: the counter is removed and `frame` is constant 0. Consequences:
  - gradient `r = x mod 2^CW`, `b = 0`.
  - checkerboard does not invert.
  - EOF still latches `mode`.

## Test plan

- Reset, then 1 full frame at defaults with mode = 0:
  - first visible output pixel (cycle 1) is r = 8'h10, g = 8'h50, b = 8'h03.
  - pixel x = 21, y = 0 gives 8'hF0, 8'h70, 8'h13.
  - de/hsync/vsync match control delayed by exactly 1 cycle.
- Mode = 1, CW = 8: BW = 80.
  - x = 0..79 white FF/FF/FF; x = 80 yellow FF/FF/00; x = 560..639 black.
  - Bars repeat identically on line 1.
- Mode changes 0→2 at line 100: grid continues to end of frame. Next frame, pixel (5,3) is r = 5+1 = 6, g = 3, b = 1 (ANIM_EN defined).
- CW = 10, mode 3: white pixel is 10'h3FF. Squares flip at x = 32 and y = 32. The whole board inverts after frame wraps past 31 → 32.
- Assert `reset` for 1 cycle mid-line in frame 7 with mode = 2. Next cycle all outputs are 0 and frame = 0. Output restarts at pixel (0,0) in mode 0.
- Build without `VIDEO_PATTERN_ANIM_EN`: after 3 frames `frame` = 0, mode 2 gives b = 0, and the checkerboard is unchanged between frames.
